// File: rtl/serial_tx_if.sv
// serial_tx_if: word handshake into the serial transmitter.
// master drives data/valid, slave returns ready.
interface serial_tx_if #(
  parameter int N = 8
);
  logic [N-1:0] data_in;
  logic         valid_in;
  logic         ready_out;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out
  );
endinterface

// File: rtl/serial_tx.sv
// serial_tx: framed parallel-to-serial transmitter, idle-high line.
// Define SERIAL_TX_PARITY_EN to add an odd parity bit after the data.
module serial_tx #(
  parameter int N         = 8,
  parameter int DIV       = 4,
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_tx_if.slave  bus,
  output logic        outstream,
  output logic        busy,
  output logic        done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(N);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;
`endif

  state_t          state_q;
  state_t          state_d;
  logic [DW-1:0]   div_q;
  logic [DW-1:0]   div_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [N-1:0]    sreg_q;
  logic [N-1:0]    sreg_d;
  logic            line_d;
  logic            done_d;
  logic            bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic            par_q;
  logic            par_d;
`endif

  assign bit_end       = (div_q == DW'(DIV - 1));
  assign bus.ready_out = (state_q == IDLE);
  assign busy          = (state_q != IDLE);

  // Next-state, divider, bit counter and shift register.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    done_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE && !bit_end) begin
      div_d = div_q + DW'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          sreg_d  = bus.data_in;
          cnt_d   = '0;
          state_d = START;
`ifdef SERIAL_TX_PARITY_EN
          par_d   = ~^bus.data_in;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          sreg_d = {1'b0, sreg_q[N-1:1]};
          if (cnt_q == CW'(N - 1)) begin
            cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (cnt_q == CW'(STOP_BITS - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, so outstream is a flop.
  always_comb begin
    line_d = 1'b1;
    unique case (1'b1)
      (state_d == START): line_d = 1'b0;
      (state_d == DATA):  line_d = sreg_d[0];
`ifdef SERIAL_TX_PARITY_EN
      (state_d == PARITY): line_d = par_d;
`endif
      default: line_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      sreg_q    <= '0;
      outstream <= 1'b1;
      done      <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      sreg_q    <= sreg_d;
      outstream <= line_d;
      done      <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed frame checks for serial_tx.
// Two instances: DIV=4/1 stop bit and DIV=1/2 stop bits.
module tb_serial_tx;

  localparam int N = 8;
  localparam int DIV = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L0 = (1 + N + P + 1) * DIV;
  localparam int L1 = (1 + N + P + 2);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_tx_if #(.N(N)) if0 ();
  serial_tx_if #(.N(N)) if1 ();

  logic out0, busy0, done0;
  logic out1, busy1, done1;

  serial_tx #(
    .N(N), .DIV(DIV), .STOP_BITS(1)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .bus(if0.slave),
    .outstream(out0), .busy(busy0),
    .done(done0)
  );

  serial_tx #(
    .N(N), .DIV(1), .STOP_BITS(2)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .bus(if1.slave),
    .outstream(out1), .busy(busy1),
    .done(done1)
  );

  int errs = 0;
  int checks = 0;

  logic la [0:79];
  logic ba [0:79];
  logic da [0:79];
  logic ra [0:79];

  // Expected line level for frame bit k.
  function automatic logic exp_bit(
    input logic [7:0] d,
    input int k
  );
    if (k == 0) return 1'b0;
    if (k <= N) return d[k-1];
    if (P == 1 && k == N + 1) return ~^d;
    return 1'b1;
  endfunction

  task automatic cap0(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      la[i] = out0;
      ba[i] = busy0;
      da[i] = done0;
      ra[i] = if0.ready_out;
    end
  endtask

  task automatic cap1(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      la[i] = out1;
      ba[i] = busy1;
      da[i] = done1;
      ra[i] = if1.ready_out;
    end
  endtask

  task automatic hs0(input logic [7:0] d);
    @(negedge clk);
    if0.data_in  = d;
    if0.valid_in = 1'b1;
    @(posedge clk);
    #1 if0.valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if0.valid_in = 1'b0;
    if0.data_in  = '0;
    if1.valid_in = 1'b0;
    if1.data_in  = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out0, if0.ready_out, busy0, done0}
        !== 4'b1100) begin
      errs++;
      $display("FAIL reset0 got %b exp 1100",
        {out0, if0.ready_out, busy0, done0});
    end
    checks++;
    if ({out1, if1.ready_out, busy1, done1}
        !== 4'b1100) begin
      errs++;
      $display("FAIL reset1 got %b exp 1100",
        {out1, if1.ready_out, busy1, done1});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({out0, busy0, done0} !== 3'b100) begin
      errs++;
      $display("FAIL idle0 got %b exp 100",
        {out0, busy0, done0});
    end
  endtask

  task automatic test_frame(
    input string nm,
    input logic [7:0] d
  );
    hs0(d);
    cap0(L0 + 2);
    for (int c = 0; c < L0; c++) begin
      checks++;
      if (la[c] !== exp_bit(d, c / DIV)) begin
        errs++;
        $display("FAIL %s line c=%0d got %b exp %b",
          nm, c, la[c], exp_bit(d, c / DIV));
      end
      checks++;
      if ({ba[c], ra[c], da[c]} !== 3'b100) begin
        errs++;
        $display("FAIL %s bsy/rdy/done c=%0d got %b exp 100",
          nm, c, {ba[c], ra[c], da[c]});
      end
    end
    checks++;
    if ({la[L0], ba[L0], ra[L0], da[L0]}
        !== 4'b1011) begin
      errs++;
      $display("FAIL %s end got %b exp 1011",
        nm, {la[L0], ba[L0], ra[L0], da[L0]});
    end
    checks++;
    if (da[L0+1] !== 1'b0) begin
      errs++;
      $display("FAIL %s done_once got %b exp 0",
        nm, da[L0+1]);
    end
  endtask

  task automatic test_parity();
    test_frame("p07", 8'h07);
    checks++;
    if (la[(N + 1) * DIV] !== ((P == 1) ? 1'b0 : 1'b1)) begin
      errs++;
      $display("FAIL p07 bit9 got %b exp %b",
        la[(N + 1) * DIV], (P == 1) ? 1'b0 : 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    if0.data_in  = 8'h01;
    if0.valid_in = 1'b1;
    @(posedge clk);
    #1;
    cap0(L0 + 1);
    if0.data_in = 8'hFF;
    for (int c = 0; c < L0; c++) begin
      checks++;
      if (la[c] !== exp_bit(8'h01, c / DIV)) begin
        errs++;
        $display("FAIL b2b_a c=%0d got %b exp %b",
          c, la[c], exp_bit(8'h01, c / DIV));
      end
    end
    checks++;
    if ({la[L0], ra[L0], da[L0]} !== 3'b111) begin
      errs++;
      $display("FAIL b2b_gap got %b exp 111",
        {la[L0], ra[L0], da[L0]});
    end
    @(posedge clk);
    #1 if0.valid_in = 1'b0;
    cap0(L0 + 1);
    for (int c = 0; c < L0; c++) begin
      checks++;
      if (la[c] !== exp_bit(8'hFF, c / DIV)) begin
        errs++;
        $display("FAIL b2b_b c=%0d got %b exp %b",
          c, la[c], exp_bit(8'hFF, c / DIV));
      end
    end
    checks++;
    if (da[L0] !== 1'b1) begin
      errs++;
      $display("FAIL b2b_done got %b exp 1", da[L0]);
    end
  endtask

  task automatic test_ignore();
    hs0(8'h3C);
    for (int c = 0; c < L0 + 8; c++) begin
      @(negedge clk);
      la[c] = out0;
      ba[c] = busy0;
      da[c] = done0;
      if (c == 10) begin
        if0.data_in  = 8'h00;
        if0.valid_in = 1'b1;
      end
      if (c == 11) if0.valid_in = 1'b0;
      if (c == 20) if0.data_in = 8'hFF;
    end
    if0.valid_in = 1'b0;
    for (int c = 0; c < L0; c++) begin
      checks++;
      if (la[c] !== exp_bit(8'h3C, c / DIV)) begin
        errs++;
        $display("FAIL ign c=%0d got %b exp %b",
          c, la[c], exp_bit(8'h3C, c / DIV));
      end
    end
    checks++;
    if (da[L0] !== 1'b1) begin
      errs++;
      $display("FAIL ign_done got %b exp 1", da[L0]);
    end
    for (int c = L0 + 1; c < L0 + 8; c++) begin
      checks++;
      if ({la[c], ba[c], da[c]} !== 3'b100) begin
        errs++;
        $display("FAIL ign_extra c=%0d got %b exp 100",
          c, {la[c], ba[c], da[c]});
      end
    end
  endtask

  task automatic test_reset_mid();
    hs0(8'hF0);
    repeat (18) @(negedge clk);
    checks++;
    if (out0 !== 1'b0) begin
      errs++;
      $display("FAIL rmid_bit3 got %b exp 0", out0);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({out0, if0.ready_out, busy0, done0}
        !== 4'b1100) begin
      errs++;
      $display("FAIL rmid_async got %b exp 1100",
        {out0, if0.ready_out, busy0, done0});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out0, busy0, done0} !== 3'b100) begin
        errs++;
        $display("FAIL rmid_hold i=%0d got %b exp 100",
          i, {out0, busy0, done0});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({out0, busy0, done0} !== 3'b100) begin
      errs++;
      $display("FAIL rmid_rel got %b exp 100",
        {out0, busy0, done0});
    end
    test_frame("r81", 8'h81);
  endtask

  task automatic test_div1();
    @(negedge clk);
    if1.data_in  = 8'h55;
    if1.valid_in = 1'b1;
    @(posedge clk);
    #1 if1.valid_in = 1'b0;
    cap1(L1 + 2);
    for (int c = 0; c < L1; c++) begin
      checks++;
      if (la[c] !== exp_bit(8'h55, c)) begin
        errs++;
        $display("FAIL div1 c=%0d got %b exp %b",
          c, la[c], exp_bit(8'h55, c));
      end
      checks++;
      if ({ba[c], da[c]} !== 2'b10) begin
        errs++;
        $display("FAIL div1_bsy c=%0d got %b exp 10",
          c, {ba[c], da[c]});
      end
    end
    checks++;
    if ({la[L1], ba[L1], ra[L1], da[L1]}
        !== 4'b1011) begin
      errs++;
      $display("FAIL div1_end got %b exp 1011",
        {la[L1], ba[L1], ra[L1], da[L1]});
    end
    checks++;
    if (da[L1+1] !== 1'b0) begin
      errs++;
      $display("FAIL div1_once got %b exp 0", da[L1+1]);
    end
  endtask

  initial begin
    test_reset();
    test_frame("a5", 8'hA5);
    test_parity();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    test_div1();
    $display("Result: errors=%0d of %0d checks",
      errs, checks);
    $finish;
  end

endmodule
